// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing presets, sync polarity constants and the decoded sync-flag bundle.
package vga_timing_gen_pkg;

  localparam logic POL_NEG = 1'b0;
  localparam logic POL_POS = 1'b1;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  // 800x600 @ 72 Hz, 50 MHz pixel clock, positive syncs, needs CX_W=11
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 56;
  localparam int SVGA800_H_SYNC   = 120;
  localparam int SVGA800_H_BP     = 64;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 37;
  localparam int SVGA800_V_SYNC   = 6;
  localparam int SVGA800_V_BP     = 23;

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } sync_t;

endpackage

// File: rtl/vga_sync_delay.sv
// CE-gated shift register that aligns decoded sync flags with a pipelined pixel path.
module vga_sync_delay #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ce,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
    end else if (i_ce) begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: undelayed pixel/line counters plus delayed sync, blank and area flags.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int   H_ACTIVE = VGA640_H_ACTIVE,
  parameter int   H_FP     = VGA640_H_FP,
  parameter int   H_SYNC   = VGA640_H_SYNC,
  parameter int   H_BP     = VGA640_H_BP,
  parameter int   V_ACTIVE = VGA640_V_ACTIVE,
  parameter int   V_FP     = VGA640_V_FP,
  parameter int   V_SYNC   = VGA640_V_SYNC,
  parameter int   V_BP     = VGA640_V_BP,
  parameter logic HS_POL   = POL_NEG,
  parameter logic VS_POL   = POL_NEG,
  parameter int   PIPE_DLY = 1,
  parameter int   CX_W     = 10,
  parameter int   CY_W     = 10
) (
  input  logic            VGA_CLK,
  input  logic            RESET,
  input  logic            CE,
  output logic [CX_W-1:0] CounterX,
  output logic [CY_W-1:0] CounterY,
  output logic            LINE_START,
  output logic            FRAME_START,
  output logic            VGA_AREA,
  output logic            VGA_HS,
  output logic            VGA_VS,
  output logic            VGA_BLANK_N,
  output logic            VGA_SYNC_N
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CX_W-1:0] X_LAST = CX_W'(H_TOTAL - 1);
  localparam logic [CY_W-1:0] Y_LAST = CY_W'(V_TOTAL - 1);

  // One extra bit so a sync window ending exactly at 2**W still compares correctly
  localparam logic [CX_W:0] X_ACT_END = (CX_W+1)'(H_ACTIVE);
  localparam logic [CX_W:0] X_HS_BEG  = (CX_W+1)'(H_ACTIVE + H_FP);
  localparam logic [CX_W:0] X_HS_END  = (CX_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CY_W:0] Y_ACT_END = (CY_W+1)'(V_ACTIVE);
  localparam logic [CY_W:0] Y_VS_BEG  = (CY_W+1)'(V_ACTIVE + V_FP);
  localparam logic [CY_W:0] Y_VS_END  = (CY_W+1)'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > (1 << CX_W)) begin : g_bad_cx_w
    $error("vga_timing_gen: CX_W too small for H_TOTAL");
  end
  if (V_TOTAL > (1 << CY_W)) begin : g_bad_cy_w
    $error("vga_timing_gen: CY_W too small for V_TOTAL");
  end
  if (PIPE_DLY < 1) begin : g_bad_dly
    $error("vga_timing_gen: PIPE_DLY must be at least 1");
  end

  logic [CX_W-1:0] r_x;
  logic [CY_W-1:0] r_y;
  logic [CX_W:0]   w_x_ext;
  logic [CY_W:0]   w_y_ext;
  sync_t           w_dec;
  sync_t           w_dly;

  always_ff @(posedge VGA_CLK) begin
    if (RESET) begin
      r_x <= '0;
      r_y <= '0;
    end else if (CE) begin
      if (r_x == X_LAST) begin
        r_x <= '0;
        r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign w_x_ext   = {1'b0, r_x};
  assign w_y_ext   = {1'b0, r_y};
  assign w_dec.act = (w_x_ext < X_ACT_END) && (w_y_ext < Y_ACT_END);
  assign w_dec.hs  = (w_x_ext >= X_HS_BEG) && (w_x_ext < X_HS_END);
  assign w_dec.vs  = (w_y_ext >= Y_VS_BEG) && (w_y_ext < Y_VS_END);

  // Flags are stored as "asserted" bits so a zero reset vector means fully inactive
  vga_sync_delay #(
    .WIDTH   ($bits(sync_t)),
    .DEPTH   (PIPE_DLY),
    .RST_VAL ('0)
  ) u_sync_delay (
    .i_clk (VGA_CLK),
    .i_rst (RESET),
    .i_ce  (CE),
    .i_d   (w_dec),
    .o_q   (w_dly)
  );

  assign CounterX    = r_x;
  assign CounterY    = r_y;
  assign LINE_START  = CE & (r_x == '0);
  assign FRAME_START = CE & (r_x == '0) & (r_y == '0);
  assign VGA_AREA    = w_dly.act;
  assign VGA_BLANK_N = w_dly.act;
  assign VGA_HS      = w_dly.hs ? HS_POL : ~HS_POL;
  assign VGA_VS      = w_dly.vs ? VS_POL : ~VS_POL;
  assign VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: default 640x480, a reduced raster with PIPE_DLY=3, and a tiny positive-sync raster.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic ce, rst;

  logic [9:0] x0, y0;
  logic       ls0, fs0, ar0, hs0, vs0, bn0, sn0;
  logic [4:0] x1, y1;
  logic       ls1, fs1, ar1, hs1, vs1, bn1, sn1;
  logic [2:0] x2, y2;
  logic       ls2, fs2, ar2, hs2, vs2, bn2, sn2;

  vga_timing_gen u_dut0 (
    .VGA_CLK(clk), .RESET(rst), .CE(ce),
    .CounterX(x0), .CounterY(y0), .LINE_START(ls0), .FRAME_START(fs0),
    .VGA_AREA(ar0), .VGA_HS(hs0), .VGA_VS(vs0), .VGA_BLANK_N(bn0), .VGA_SYNC_N(sn0)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(3), .CX_W(5), .CY_W(5)
  ) u_dut1 (
    .VGA_CLK(clk), .RESET(rst), .CE(ce),
    .CounterX(x1), .CounterY(y1), .LINE_START(ls1), .FRAME_START(fs1),
    .VGA_AREA(ar1), .VGA_HS(hs1), .VGA_VS(vs1), .VGA_BLANK_N(bn1), .VGA_SYNC_N(sn1)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(1), .CX_W(3), .CY_W(3)
  ) u_dut2 (
    .VGA_CLK(clk), .RESET(rst), .CE(ce),
    .CounterX(x2), .CounterY(y2), .LINE_START(ls2), .FRAME_START(fs2),
    .VGA_AREA(ar2), .VGA_HS(hs2), .VGA_VS(vs2), .VGA_BLANK_N(bn2), .VGA_SYNC_N(sn2)
  );

  // Hand-entered raster tables for the three instances
  int c_hact[3] = '{640, 16, 4};
  int c_hfp [3] = '{16, 2, 1};
  int c_hsw [3] = '{96, 4, 2};
  int c_hbp [3] = '{48, 2, 1};
  int c_vact[3] = '{480, 12, 3};
  int c_vfp [3] = '{10, 1, 1};
  int c_vsw [3] = '{2, 2, 1};
  int c_vbp [3] = '{33, 2, 1};
  bit c_hpol[3] = '{1'b0, 1'b0, 1'b1};
  bit c_vpol[3] = '{1'b0, 1'b0, 1'b1};
  int c_dly [3] = '{1, 3, 1};

  typedef struct {
    int d;
    int x;
    int y;
    bit ls;
    bit fs;
    bit ar;
    bit hs;
    bit vs;
    bit bn;
    bit sn;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   sb_on   = 1'b0;

  // Model: a linear pixel index per instance plus the indices seen at the last CE ticks (-1 = reset)
  int m_n   [3];
  int m_hist[3][3];

  function automatic int ht(int d);
    return c_hact[d] + c_hfp[d] + c_hsw[d] + c_hbp[d];
  endfunction

  function automatic int vt(int d);
    return c_vact[d] + c_vfp[d] + c_vsw[d] + c_vbp[d];
  endfunction

  function automatic exp_t expect_now(int d, bit c);
    exp_t e;
    int   px, py, old, ox, oy;
    bit   a, h, v;
    px = m_n[d] % ht(d);
    py = m_n[d] / ht(d);
    old = m_hist[d][c_dly[d]-1];
    a = 1'b0; h = 1'b0; v = 1'b0;
    if (old >= 0) begin
      ox = old % ht(d);
      oy = old / ht(d);
      a = (ox < c_hact[d]) && (oy < c_vact[d]);
      h = (ox >= c_hact[d] + c_hfp[d]) && (ox < c_hact[d] + c_hfp[d] + c_hsw[d]);
      v = (oy >= c_vact[d] + c_vfp[d]) && (oy < c_vact[d] + c_vfp[d] + c_vsw[d]);
    end
    e.d  = d;
    e.x  = px;
    e.y  = py;
    e.ls = c && (px == 0);
    e.fs = c && (px == 0) && (py == 0);
    e.ar = a;
    e.hs = h ? c_hpol[d] : !c_hpol[d];
    e.vs = v ? c_vpol[d] : !c_vpol[d];
    e.bn = a;
    e.sn = 1'b0;
    return e;
  endfunction

  task automatic model_edge(int d, bit c, bit r);
    if (r) begin
      m_n[d] = 0;
      for (int i = 0; i < 3; i++) m_hist[d][i] = -1;
    end else if (c) begin
      for (int i = 2; i > 0; i--) m_hist[d][i] = m_hist[d][i-1];
      m_hist[d][0] = m_n[d];
      m_n[d] = (m_n[d] + 1) % (ht(d) * vt(d));
    end
  endtask

  task automatic step(bit c, bit r);
    @(negedge clk);
    ce  = c;
    rst = r;
    if (sb_on) for (int d = 0; d < 3; d++) q.push_back(expect_now(d, c));
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_edge(d, c, r);
  endtask

  function automatic exp_t observe(int d);
    exp_t o;
    o.d = d;
    case (d)
      0: begin
        o.x = int'(x0); o.y = int'(y0); o.ls = ls0; o.fs = fs0;
        o.ar = ar0; o.hs = hs0; o.vs = vs0; o.bn = bn0; o.sn = sn0;
      end
      1: begin
        o.x = int'(x1); o.y = int'(y1); o.ls = ls1; o.fs = fs1;
        o.ar = ar1; o.hs = hs1; o.vs = vs1; o.bn = bn1; o.sn = sn1;
      end
      default: begin
        o.x = int'(x2); o.y = int'(y2); o.ls = ls2; o.fs = fs2;
        o.ar = ar2; o.hs = hs2; o.vs = vs2; o.bn = bn2; o.sn = sn2;
      end
    endcase
    return o;
  endfunction

  // Monitor: every cycle the instances present their outputs; pop and compare
  initial begin
    exp_t e, o;
    forever begin
      @(negedge clk);
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        o = observe(e.d);
        n_tests++;
        if (o.x != e.x || o.y != e.y || o.ls != e.ls || o.fs != e.fs || o.ar != e.ar ||
            o.hs != e.hs || o.vs != e.vs || o.bn != e.bn || o.sn != e.sn) begin
          n_fail++;
          $display("FAIL dut%0d_cycle t=%0t: got x=%0d y=%0d ls=%0b fs=%0b area=%0b hs=%0b vs=%0b bn=%0b sn=%0b, expected x=%0d y=%0d ls=%0b fs=%0b area=%0b hs=%0b vs=%0b bn=%0b sn=%0b",
                   e.d, $time, o.x, o.y, o.ls, o.fs, o.ar, o.hs, o.vs, o.bn, o.sn,
                   e.x, e.y, e.ls, e.fs, e.ar, e.hs, e.vs, e.bn, e.sn);
        end
      end
    end
  end

  // Period and pulse-width measurements for the directed checks
  int cyc = 0;
  int last_ls0 = -1, line_per0 = 0;
  int hs_lo_cnt0 = 0, hs_w0 = 0, hs_fall_x0 = -1;
  bit prev_hs0 = 1'b1;
  int last_fs1 = -1, frame_per1 = 0;
  int vs_lo_cnt1 = 0, vs_w1 = 0;
  bit prev_vs1 = 1'b1;

  always @(negedge clk) begin
    #3;
    cyc++;
    if (ls0) begin
      if (last_ls0 >= 0) line_per0 = cyc - last_ls0;
      last_ls0 = cyc;
    end
    if (!hs0) begin
      if (prev_hs0) hs_fall_x0 = int'(x0);
      hs_lo_cnt0++;
    end else if (!prev_hs0) begin
      hs_w0 = hs_lo_cnt0;
      hs_lo_cnt0 = 0;
    end
    prev_hs0 = hs0;
    if (fs1) begin
      if (last_fs1 >= 0) frame_per1 = cyc - last_fs1;
      last_fs1 = cyc;
    end
    if (!vs1) begin
      vs_lo_cnt1++;
    end else if (!prev_vs1) begin
      vs_w1 = vs_lo_cnt1;
      vs_lo_cnt1 = 0;
    end
    prev_vs1 = vs1;
  end

  task automatic check(string nm, int act, int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  initial begin
    ce  = 1'b0;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      m_n[d] = 0;
      for (int i = 0; i < 3; i++) m_hist[d][i] = -1;
    end

    step(1'b1, 1'b1);
    sb_on = 1'b1;
    repeat (2) step(1'b1, 1'b1);

    // Free run: several small frames, default raster lines with HS
    repeat (2000) step(1'b1, 1'b0);
    check("line_period_ce1", line_per0, 800);
    check("hs_low_width", hs_w0, 96);
    check("hs_fall_at_x", hs_fall_x0, 657);
    check("mid_frame_period", frame_per1, 24 * 17);
    check("mid_vs_low_width", vs_w1, 2 * 24);

    // Half-rate pixel enable
    for (int i = 0; i < 3400; i++) step((i % 2) == 0, 1'b0);
    check("line_period_ce_half", line_per0, 1600);

    // Reset in the middle of a line
    for (int i = 0; i < 2000 && (m_n[0] % 800) != 300; i++) step(1'b1, 1'b0);
    #1;
    check("x_before_reset", int'(x0), 300);
    step(1'b1, 1'b1);
    #1;
    check("x_after_reset", int'(x0), 0);
    check("hs_after_reset", int'(hs0), 1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    repeat (1500) step(1'b1, 1'b0);

    // Irregular enable pattern
    for (int i = 0; i < 1200; i++) step((i % 3) != 0, 1'b0);

    @(negedge clk);
    #4;
    check("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
